// File: rtl/laser_countdown_timer.sv
// laser_countdown_timer
// Countdown timer used by the laser on/off controller to set the on-time.
// Counts N prescaled ticks while Ec is high and then emits a one-cycle
// terminal pulse Z. Done stays high until Rc reloads the timer.
// All outputs come straight from registers, so no input reaches an output
// combinationally.

module laser_countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int N        = 16,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Ec,
  input  logic             Rc,
  output logic             Z,
  output logic             Done,
  output logic [WIDTH-1:0] Count
);

  // The prescale counter is at least one bit wide. When PRESCALE is 1 it
  // stays at zero, so every enabled edge is one tick.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] N_VAL    = WIDTH'(N);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  // Reject parameter values the counter cannot represent.
  generate
    if (N < 1 || longint'(N) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_n
      $error("laser_countdown_timer: N must be in 1 .. 2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("laser_countdown_timer: PRESCALE must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [PRE_W-1:0] r_pre;
  logic             r_z;
  logic             r_done;

  // Combined decode of the end of a prescale period.
  logic w_pre_wrap;
  assign w_pre_wrap = (r_pre == PRE_MAX);

  // Control FSM: reload beats enable, and enable beats hold. Z and Done are registered here.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_LOAD;
      r_count <= N_VAL;
      r_pre   <= '0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Z is a single-cycle pulse. It drops on every edge unless expiry sets it again.
      r_z <= 1'b0;
      if (Rc) begin
        r_state <= S_LOAD;
        r_count <= N_VAL;
        r_pre   <= '0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD, S_RUN: begin
            if (Ec) begin
              r_state <= S_RUN;
              if (w_pre_wrap) begin
                r_pre <= '0;
                if (r_count == CNT_ONE) begin
                  r_count <= CNT_ZERO;
                  r_state <= S_DONE;
                  r_z     <= 1'b1;
                  r_done  <= 1'b1;
                end else if (r_count != CNT_ZERO) begin
                  r_count <= r_count - CNT_ONE;
                end
              end else begin
                r_pre <= r_pre + PRE_W'(1);
              end
            end
            // With Ec low, the count, the partial prescale and the state all hold.
          end
          S_DONE: begin
            // The count saturates at zero. Enable is ignored until a reload.
            r_count <= CNT_ZERO;
            r_done  <= 1'b1;
          end
          default: begin
            // The unused encoding recovers to a freshly loaded timer.
            r_state <= S_LOAD;
            r_count <= N_VAL;
            r_pre   <= '0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Z     = r_z;
  assign Done  = r_done;
  assign Count = r_count;

endmodule

// File: tb/tb_laser_countdown_timer.sv
// Directed testbench for laser_countdown_timer.
// Instance A uses N=16 and PRESCALE=1. Instance B uses N=16 and PRESCALE=4.
// Both instances share the clock and the reset.

module tb_laser_countdown_timer;

  localparam int W = 16;

  logic         Clk;
  logic         Rst;
  logic         ec_a, rc_a, ec_b, rc_b;
  logic         z_a, done_a, z_b, done_b;
  logic [W-1:0] count_a, count_b;

  int n_checks;
  int n_errors;

  laser_countdown_timer #(.WIDTH(W), .N(16), .PRESCALE(1)) u_dut_a (
    .Clk   (Clk),
    .Rst   (Rst),
    .Ec    (ec_a),
    .Rc    (rc_a),
    .Z     (z_a),
    .Done  (done_a),
    .Count (count_a)
  );

  laser_countdown_timer #(.WIDTH(W), .N(16), .PRESCALE(4)) u_dut_b (
    .Clk   (Clk),
    .Rst   (Rst),
    .Ec    (ec_b),
    .Rc    (rc_b),
    .Z     (z_b),
    .Done  (done_b),
    .Count (count_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge. Outputs are sampled and inputs are driven 1 ns after it.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    // Power-on reset state for both instances.
    tick;
    tick;
    n_checks++;
    if (count_a !== 16'd16 || z_a !== 1'b0 || done_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_init_a got count=%0d z=%b done=%b exp count=16 z=0 done=0", count_a, z_a, done_a);
    end
    n_checks++;
    if (count_b !== 16'd16 || z_b !== 1'b0 || done_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_init_b got count=%0d z=%b done=%b exp count=16 z=0 done=0", count_b, z_b, done_b);
    end
    Rst = 1'b0;
    // Count a few ticks, then reset in mid-cycle and check before the next edge.
    ec_a = 1'b1;
    tick;
    tick;
    tick;
    n_checks++;
    if (count_a !== 16'd13) begin
      n_errors++;
      $display("FAIL reset_precount got count=%0d exp 13", count_a);
    end
    #3;
    Rst = 1'b1;
    #1;
    n_checks++;
    if (count_a !== 16'd16 || z_a !== 1'b0 || done_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async got count=%0d z=%b done=%b exp count=16 z=0 done=0", count_a, z_a, done_a);
    end
    ec_a = 1'b0;
    tick;
    Rst = 1'b0;
  endtask

  task automatic test_nominal;
    rc_a = 1'b1;
    tick;
    rc_a = 1'b0;
    ec_a = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      n_checks++;
      if (count_a !== W'(16 - k) || z_a !== (k == 16) || done_a !== (k == 16)) begin
        n_errors++;
        $display("FAIL nominal_edge%0d got count=%0d z=%b done=%b exp count=%0d z=%b done=%b",
                 k, count_a, z_a, done_a, 16 - k, (k == 16), (k == 16));
      end
    end
    // Keep Ec high. Done must hold, Z must stay low, and Count must not wrap.
    for (int k = 0; k < 4; k++) begin
      tick;
      n_checks++;
      if (count_a !== 16'd0 || z_a !== 1'b0 || done_a !== 1'b1) begin
        n_errors++;
        $display("FAIL nominal_hold%0d got count=%0d z=%b done=%b exp count=0 z=0 done=1", k, count_a, z_a, done_a);
      end
    end
    ec_a = 1'b0;
  endtask

  task automatic test_pause;
    int exp_cnt;
    rc_b = 1'b1;
    tick;
    rc_b = 1'b0;
    ec_b = 1'b1;
    for (int e = 1; e <= 10; e++) tick;
    n_checks++;
    if (count_b !== 16'd14) begin
      n_errors++;
      $display("FAIL pause_after10 got count=%0d exp 14", count_b);
    end
    ec_b = 1'b0;
    for (int p = 0; p < 5; p++) begin
      tick;
      n_checks++;
      if (count_b !== 16'd14 || z_b !== 1'b0) begin
        n_errors++;
        $display("FAIL pause_hold%0d got count=%0d z=%b exp count=14 z=0", p, count_b, z_b);
      end
    end
    // Pre was frozen at 2, so the next tick completes after two more enabled edges.
    ec_b = 1'b1;
    for (int e = 11; e <= 64; e++) begin
      tick;
      exp_cnt = 16 - (e / 4);
      n_checks++;
      if (count_b !== W'(exp_cnt) || z_b !== (e == 64)) begin
        n_errors++;
        $display("FAIL pause_edge%0d got count=%0d z=%b exp count=%0d z=%b", e, count_b, z_b, exp_cnt, (e == 64));
      end
    end
    ec_b = 1'b0;
    tick;
    n_checks++;
    if (z_b !== 1'b0 || done_b !== 1'b1) begin
      n_errors++;
      $display("FAIL pause_post got z=%b done=%b exp z=0 done=1", z_b, done_b);
    end
  endtask

  task automatic test_priority;
    rc_a = 1'b1;
    tick;
    rc_a = 1'b0;
    ec_a = 1'b1;
    for (int e = 0; e < 9; e++) tick;
    n_checks++;
    if (count_a !== 16'd7) begin
      n_errors++;
      $display("FAIL prio_pre got count=%0d exp 7", count_a);
    end
    // Rc and Ec high together: the timer reloads and does not decrement.
    rc_a = 1'b1;
    tick;
    rc_a = 1'b0;
    ec_a = 1'b0;
    n_checks++;
    if (count_a !== 16'd16 || done_a !== 1'b0 || z_a !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_reload got count=%0d done=%b z=%b exp count=16 done=0 z=0", count_a, done_a, z_a);
    end
    tick;
    n_checks++;
    if (count_a !== 16'd16) begin
      n_errors++;
      $display("FAIL prio_noload_dec got count=%0d exp 16", count_a);
    end
    // Run to expiry, then assert Rc during the Z cycle.
    ec_a = 1'b1;
    for (int e = 0; e < 16; e++) tick;
    n_checks++;
    if (z_a !== 1'b1 || count_a !== 16'd0) begin
      n_errors++;
      $display("FAIL prio_zcycle got z=%b count=%0d exp z=1 count=0", z_a, count_a);
    end
    ec_a = 1'b0;
    rc_a = 1'b1;
    tick;
    rc_a = 1'b0;
    n_checks++;
    if (z_a !== 1'b0 || count_a !== 16'd16 || done_a !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_rc_on_z got z=%b count=%0d done=%b exp z=0 count=16 done=0", z_a, count_a, done_a);
    end
  endtask

  task automatic test_async_midrun;
    ec_a = 1'b1;
    for (int e = 0; e < 11; e++) tick;
    n_checks++;
    if (count_a !== 16'd5) begin
      n_errors++;
      $display("FAIL midrun_pre got count=%0d exp 5", count_a);
    end
    #3;
    Rst = 1'b1;
    #1;
    n_checks++;
    if (count_a !== 16'd16 || z_a !== 1'b0 || done_a !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_async got count=%0d z=%b done=%b exp count=16 z=0 done=0", count_a, z_a, done_a);
    end
    tick;
    Rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick;
      n_checks++;
      if (count_a !== W'(16 - k) || z_a !== (k == 16)) begin
        n_errors++;
        $display("FAIL midrun_edge%0d got count=%0d z=%b exp count=%0d z=%b", k, count_a, z_a, 16 - k, (k == 16));
      end
    end
    ec_a = 1'b0;
  endtask

  task automatic test_back_to_back;
    int  cycles;
    bit  seen;
    // The button press reloads the timer into SLoad.
    rc_a = 1'b1;
    tick;
    rc_a = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      ec_a   = 1'b1;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 40) begin
        tick;
        cycles++;
        if (z_a === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || cycles != 16) begin
        n_errors++;
        $display("FAIL loop%0d_interval got cycles=%0d seen=%b exp cycles=16 seen=1", rep, cycles, seen);
      end
      // The controller answers Z with a single-cycle Rc. Ec then resumes on the next cycle.
      ec_a = 1'b0;
      rc_a = 1'b1;
      tick;
      rc_a = 1'b0;
      n_checks++;
      if (count_a !== 16'd16 || done_a !== 1'b0 || z_a !== 1'b0) begin
        n_errors++;
        $display("FAIL loop%0d_reload got count=%0d done=%b z=%b exp count=16 done=0 z=0", rep, count_a, done_a, z_a);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Rst  = 1'b1;
    ec_a = 1'b0;
    rc_a = 1'b0;
    ec_b = 1'b0;
    rc_b = 1'b0;
    test_reset;
    test_nominal;
    test_pause;
    test_priority;
    test_async_midrun;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
